// File: rtl/axis_data_checker.sv
// axis_data_checker: sink-side checker for the payload-generator test stream.
// Rebuilds the expected pattern per beat and checks data, tkeep, tlast and frame length.
//
// Parameters:
//   DATA_WIDTH      stream width in bits, a multiple of 32 and >= 32
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   s_axis_*        AXI-Stream sink (tdata/tkeep/tvalid/tready/tlast/tuser)
//   length          expected frame length in bytes, sampled on the first beat
//   clear           synchronous clear of the statistics counters
//   frame_done      1-cycle pulse when a frame has finished
//   frame_err       {overrun,early_last,keep,data} of the last finished frame
//   frames_ok       good frames (saturating)
//   frames_err      frames with any flag set (saturating)
//   frames_abort    frames that ended with tuser=1 (saturating)
//   first_err_beat  beat index of the first flagged beat, all-ones = none
//   bytes_rx        sum of set tkeep bits over all accepted beats
// Build option:
//   AXIS_CHECKER_BACKPRESSURE_EN  drive tready from a 16-bit LFSR
module axis_data_checker #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  input  logic                    s_axis_tuser,
  input  logic [31:0]             length,
  input  logic                    clear,
  output logic                    frame_done,
  output logic [3:0]              frame_err,
  output logic [31:0]             frames_ok,
  output logic [31:0]             frames_err,
  output logic [15:0]             frames_abort,
  output logic [31:0]             first_err_beat,
  output logic [63:0]             bytes_rx
);

  localparam int WW = DATA_WIDTH / 8;
  localparam int NS = DATA_WIDTH / 32;
  localparam logic [31:0] WW32 = 32'(WW);

  typedef enum logic {
    IDLE,
    RX
  } state_t;

  state_t state, state_nx;

  logic [31:0] exp_q, exp_nx;
  logic [31:0] len_q, len_nx;
  logic [31:0] beat_q, beat_nx;
  logic [3:0]  flags_q, flags_nx;

  logic ready_q;
  logic acc;

`ifdef AXIS_CHECKER_BACKPRESSURE_EN
  logic [15:0] lfsr_q;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_fb};
    end
  end

  assign s_axis_tready = ready_q & lfsr_q[0] & ~rst;
`else
  assign s_axis_tready = ready_q & ~rst;
`endif

  assign acc = s_axis_tvalid & s_axis_tready;

  // In IDLE the incoming beat is beat 0 of a new frame: use the live
  // length input and a fresh expected offset instead of the registers.
  logic [31:0]         cur_exp;
  logic [31:0]         cur_len;
  logic [31:0]         cur_beat;
  logic [3:0]          sticky;
  logic [DATA_WIDTH-1:0] exp_word;
  logic [WW-1:0]       keep_exp;
  logic [31:0]         rem;
  logic [32:0]         next_end;
  logic                data_bad;
  logic                keep_bad;
  logic                early_last;
  logic                overrun;
  logic [3:0]          beat_flags;
  logic [3:0]          frame_flags;
  logic [63:0]         keep_cnt;

  always_comb begin
    cur_exp  = (state == IDLE) ? 32'd0 : exp_q;
    cur_len  = (state == IDLE) ? length : len_q;
    cur_beat = (state == IDLE) ? 32'd0 : beat_q;
    sticky   = (state == IDLE) ? 4'd0 : flags_q;

    exp_word = '0;
    for (int i = 0; i < NS; i++) begin
      if (i == 0) begin
        exp_word[32*i +: 32] = cur_exp;
      end else if (i == 1) begin
        exp_word[32*i +: 32] = ~cur_exp;
      end else begin
        exp_word[32*i +: 32] = 32'hDEADBEEF;
      end
    end

    data_bad = 1'b0;
    keep_cnt = '0;
    for (int b = 0; b < WW; b++) begin
      if (s_axis_tkeep[b] &&
          (s_axis_tdata[8*b +: 8] != exp_word[8*b +: 8])) begin
        data_bad = 1'b1;
      end
      keep_cnt = keep_cnt + 64'(s_axis_tkeep[b]);
    end

    rem = cur_len - cur_exp;
    keep_exp = '1;
    if (s_axis_tlast && (rem < WW32) && (rem != 32'd0)) begin
      for (int b = 0; b < WW; b++) begin
        keep_exp[b] = (32'(b) < rem);
      end
    end
    keep_bad = (s_axis_tkeep != keep_exp);

    // Compare without wrap so a frame near the 4 GiB boundary still ends.
    next_end   = {1'b0, cur_exp} + {1'b0, WW32};
    early_last = s_axis_tlast && (next_end < {1'b0, cur_len});
    overrun    = (cur_len == 32'd0) ||
                 (!s_axis_tlast && (next_end >= {1'b0, cur_len}));

    beat_flags  = {overrun, early_last, keep_bad, data_bad};
    frame_flags = sticky | beat_flags;
  end

  always_comb begin
    state_nx = state;
    exp_nx   = exp_q;
    len_nx   = len_q;
    beat_nx  = beat_q;
    flags_nx = flags_q;
    if (acc) begin
      exp_nx   = cur_exp + WW32;
      len_nx   = cur_len;
      beat_nx  = cur_beat + 32'd1;
      flags_nx = frame_flags;
      state_nx = s_axis_tlast ? IDLE : RX;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      exp_q   <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      flags_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state   <= state_nx;
      exp_q   <= exp_nx;
      len_q   <= len_nx;
      beat_q  <= beat_nx;
      flags_q <= flags_nx;
      ready_q <= 1'b1;
    end
  end

  logic frame_end;
  assign frame_end = acc & s_axis_tlast;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_done <= 1'b0;
      frame_err  <= '0;
    end else begin
      frame_done <= frame_end;
      if (frame_end) begin
        frame_err <= frame_flags;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      frames_ok      <= '0;
      frames_err     <= '0;
      frames_abort   <= '0;
      first_err_beat <= '1;
      bytes_rx       <= '0;
    end else begin
      if (acc) begin
        if (bytes_rx > ~keep_cnt) begin
          bytes_rx <= '1;
        end else begin
          bytes_rx <= bytes_rx + keep_cnt;
        end
        if ((|beat_flags) && (&first_err_beat)) begin
          first_err_beat <= cur_beat;
        end
      end
      if (frame_end) begin
        if (s_axis_tuser) begin
          if (!(&frames_abort)) begin
            frames_abort <= frames_abort + 16'd1;
          end
        end else if (|frame_flags) begin
          if (!(&frames_err)) begin
            frames_err <= frames_err + 32'd1;
          end
        end else begin
          if (!(&frames_ok)) begin
            frames_ok <= frames_ok + 32'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_data_checker.sv
// tb_axis_data_checker: directed bench for axis_data_checker (DATA_WIDTH=64).
// Expected frame_err values are queued per frame and popped on frame_done.
module tb_axis_data_checker;

  logic        clk;
  logic        rst;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic        tuser;
  logic [31:0] length;
  logic        clear;
  logic        frame_done;
  logic [3:0]  frame_err;
  logic [31:0] frames_ok;
  logic [31:0] frames_err;
  logic [15:0] frames_abort;
  logic [31:0] first_err_beat;
  logic [63:0] bytes_rx;

  int n_checks = 0;
  int n_fails  = 0;
  int n_done   = 0;
  logic [3:0]  sb_q[$];
  logic [63:0] bytes_m;

  axis_data_checker #(.DATA_WIDTH(64)) dut (
    .clk            (clk),
    .rst            (rst),
    .s_axis_tdata   (tdata),
    .s_axis_tkeep   (tkeep),
    .s_axis_tvalid  (tvalid),
    .s_axis_tready  (tready),
    .s_axis_tlast   (tlast),
    .s_axis_tuser   (tuser),
    .length         (length),
    .clear          (clear),
    .frame_done     (frame_done),
    .frame_err      (frame_err),
    .frames_ok      (frames_ok),
    .frames_err     (frames_err),
    .frames_abort   (frames_abort),
    .first_err_beat (first_err_beat),
    .bytes_rx       (bytes_rx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (frame_done) begin
      n_done++;
      if (sb_q.size() == 0) begin
        check("unexpected_frame_done", 64'd1, 64'd0);
      end else begin
        check("frame_err", 64'(frame_err), 64'(sb_q.pop_front()));
      end
    end
  end

  task automatic beat(input logic [31:0] e, input logic [7:0] k,
                      input logic l, input logic u, input logic c,
                      input logic [63:0] flip, input logic [3:0] eerr);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    tdata  = {~e, e} ^ flip;
    tkeep  = k;
    tlast  = l;
    tuser  = u;
    clear  = c;
    tvalid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (tready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      check("beat_timeout", 64'd0, 64'd1);
    end else begin
      if (l) sb_q.push_back(eerr);
      if (c) bytes_m = '0;
      else bytes_m = bytes_m + 64'($countones(k));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tvalid = 1'b0;
      tlast  = 1'b0;
      tuser  = 1'b0;
      clear  = 1'b0;
    end
  endtask

  task automatic good20(input logic u, input logic c);
    length = 32'd20;
    beat(32'd0,  8'hFF, 1'b0, 1'b0, 1'b0, 64'd0, 4'b0000);
    beat(32'd8,  8'hFF, 1'b0, 1'b0, 1'b0, 64'd0, 4'b0000);
    beat(32'd16, 8'h0F, 1'b1, u,    c,    64'd0, 4'b0000);
  endtask

  initial begin
    rst = 1'b1; tdata = '0; tkeep = '0; tvalid = 1'b0;
    tlast = 1'b0; tuser = 1'b0; length = '0; clear = 1'b0;
    bytes_m = '0;
    @(negedge clk);
    check("rst_tready", 64'(tready), 64'd0);
    check("rst_frames_ok", 64'(frames_ok), 64'd0);
    check("rst_first_err", 64'(first_err_beat), 64'hFFFFFFFF);
    check("rst_done", 64'({frame_done, frame_err}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("tready_after_rst", 64'(tready), 64'd1);

    good20(1'b0, 1'b0);
    idle(2);
    check("t1_ok", 64'(frames_ok), 64'd1);
    check("t1_bytes", bytes_rx, 64'd20);
    check("t1_first_err", 64'(first_err_beat), 64'hFFFFFFFF);

    length = 32'd20;
    beat(32'd0,  8'hFF, 1'b0, 1'b0, 1'b0, 64'd0, 4'b0000);
    beat(32'd8,  8'hFF, 1'b0, 1'b0, 1'b0, 64'h8, 4'b0000);
    beat(32'd16, 8'h0F, 1'b1, 1'b0, 1'b0, 64'd0, 4'b0001);
    idle(2);
    check("t2_err", 64'(frames_err), 64'd1);
    check("t2_first_err", 64'(first_err_beat), 64'd1);
    check("t2_ok", 64'(frames_ok), 64'd1);

    length = 32'd24;
    beat(32'd0, 8'hFF, 1'b0, 1'b0, 1'b0, 64'd0, 4'b0000);
    beat(32'd8, 8'hFF, 1'b1, 1'b0, 1'b0, 64'd0, 4'b0100);
    idle(2);
    check("t3_err", 64'(frames_err), 64'd2);
    check("t3_first_err", 64'(first_err_beat), 64'd1);

    length = 32'd16;
    beat(32'd0, 8'hFF, 1'b0, 1'b0, 1'b0, 64'd0, 4'b0000);
    beat(32'd8, 8'h0F, 1'b1, 1'b0, 1'b0, 64'd0, 4'b0010);
    idle(2);
    check("t4_err", 64'(frames_err), 64'd3);
    check("t4_bytes", bytes_rx, bytes_m);

    good20(1'b1, 1'b0);
    idle(2);
    check("t5_abort", 64'(frames_abort), 64'd1);
    check("t5_ok", 64'(frames_ok), 64'd1);
    check("t5_err", 64'(frames_err), 64'd3);

    good20(1'b0, 1'b1);
    idle(2);
    check("clr_ok", 64'(frames_ok), 64'd0);
    check("clr_err", 64'(frames_err), 64'd0);
    check("clr_abort", 64'(frames_abort), 64'd0);
    check("clr_bytes", bytes_rx, 64'd0);
    check("clr_first_err", 64'(first_err_beat), 64'hFFFFFFFF);

    length = 32'd8;
    beat(32'd0, 8'hFF, 1'b0, 1'b0, 1'b0, 64'd0, 4'b0000);
    beat(32'd8, 8'hFF, 1'b1, 1'b0, 1'b0, 64'd0, 4'b1000);
    idle(2);
    check("ovr_err", 64'(frames_err), 64'd1);
    check("ovr_first_err", 64'(first_err_beat), 64'd0);
    check("ovr_bytes", bytes_rx, bytes_m);

    length = 32'd20;
    beat(32'd0, 8'hFF, 1'b0, 1'b0, 1'b0, 64'd0, 4'b0000);
    beat(32'd8, 8'hFF, 1'b0, 1'b0, 1'b0, 64'd0, 4'b0000);
    @(negedge clk);
    tvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_tready", 64'(tready), 64'd0);
    rst = 1'b0;
    bytes_m = '0;
    good20(1'b0, 1'b0);
    idle(2);
    check("t6_ok", 64'(frames_ok), 64'd1);
    check("t6_err", 64'(frames_err), 64'd0);
    check("t6_bytes", bytes_rx, 64'd20);

`ifdef AXIS_CHECKER_BACKPRESSURE_EN
    for (int f = 0; f < 100; f++) begin
      good20(1'b0, 1'b0);
    end
    idle(2);
    check("bp_ok", 64'(frames_ok), 64'd101);
    check("bp_err", 64'(frames_err), 64'd0);
`endif

    idle(2);
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    check("done_count", 64'(n_done),
`ifdef AXIS_CHECKER_BACKPRESSURE_EN
          64'd108);
`else
          64'd8);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
